// File: rtl/bit_comparator.sv
`default_nettype none
// ============================================================================
// Module   : bit_comparator
// Purpose  : 2-bit unsigned magnitude comparator with optional input
//            synchronizers and registered one-hot gt/eq/lt flags.
//            Optional statistics counters are enabled by defining BC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bit_comparator #(
    parameter int OUT_REG     = 1,
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a1,
    input  logic             a2,
    input  logic             b1,
    input  logic             b2,
    output logic             c,
    output logic             d,
    output logic             e
`ifdef BC_STATS_EN
    ,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
`endif
);

    localparam logic [2:0] RST_FLAGS = 3'b010;

    logic       run_q;
    logic [3:0] ops;
    logic       gt_d;
    logic       eq_d;
    logic       lt_d;

    if (SYNC_STAGES < 0 || SYNC_STAGES > 3 || CNT_W < 1) begin : g_param_check
        $error("bit_comparator: SYNC_STAGES must be 0..3 and CNT_W >= 1");
    end

    // Single release flop: every state flop first updates on the second edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    if (SYNC_STAGES > 0) begin : g_sync
        logic [3:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= 4'b0000;
                end
            end else if (run_q) begin
                sync_q[0] <= {a1, a2, b1, b2};
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign ops = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign ops = {a1, a2, b1, b2};
    end

    // ops = {A[1], A[0], B[1], B[0]}
    always_comb begin
        gt_d = (ops[3] & ~ops[1]) | (~(ops[3] ^ ops[1]) & ops[2] & ~ops[0]);
        eq_d = ~(ops[3] ^ ops[1]) & ~(ops[2] ^ ops[0]);
        lt_d = ~gt_d & ~eq_d;
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [2:0] flags_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                flags_q <= RST_FLAGS;
            end else if (run_q) begin
                flags_q <= {gt_d, eq_d, lt_d};
            end
        end

        assign {c, d, e} = flags_q;
    end else begin : g_out_comb
        assign {c, d, e} = {gt_d, eq_d, lt_d};
    end

`ifdef BC_STATS_EN
    logic             cnt_en_q;
    logic [CNT_W-1:0] gt_cnt_q;
    logic [CNT_W-1:0] eq_cnt_q;
    logic [CNT_W-1:0] lt_cnt_q;

    // cnt_en_q lags run_q so the reset-held flags are never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_en_q <= 1'b0;
            gt_cnt_q <= '0;
            eq_cnt_q <= '0;
            lt_cnt_q <= '0;
        end else begin
            cnt_en_q <= run_q;
            if (cnt_en_q) begin
                if (c && (gt_cnt_q != {CNT_W{1'b1}})) gt_cnt_q <= gt_cnt_q + 1'b1;
                if (d && (eq_cnt_q != {CNT_W{1'b1}})) eq_cnt_q <= eq_cnt_q + 1'b1;
                if (e && (lt_cnt_q != {CNT_W{1'b1}})) lt_cnt_q <= lt_cnt_q + 1'b1;
            end
        end
    end

    assign gt_cnt = gt_cnt_q;
    assign eq_cnt = eq_cnt_q;
    assign lt_cnt = lt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_comparator
// Purpose  : Directed, table-driven self-checking bench for bit_comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_comparator;

    logic clk;
    logic rst_n;
    logic a1, a2, b1, b2;

    logic cr, dr, er;   // OUT_REG=1, SYNC_STAGES=0
    logic cs, ds, es;   // OUT_REG=1, SYNC_STAGES=2
    logic cc, dc, ec;   // OUT_REG=0, SYNC_STAGES=0

    int n_chk;
    int n_fail;

`ifdef BC_STATS_EN
    logic [3:0] gt_cnt, eq_cnt, lt_cnt;
    logic [7:0] gt_cnt_s, eq_cnt_s, lt_cnt_s;
    logic [7:0] gt_cnt_c, eq_cnt_c, lt_cnt_c;
`endif

    bit_comparator #(.OUT_REG(1), .SYNC_STAGES(0), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
        .c(cr), .d(dr), .e(er)
`ifdef BC_STATS_EN
        , .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
`endif
    );

    bit_comparator #(.OUT_REG(1), .SYNC_STAGES(2)) dut_sync (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
        .c(cs), .d(ds), .e(es)
`ifdef BC_STATS_EN
        , .gt_cnt(gt_cnt_s), .eq_cnt(eq_cnt_s), .lt_cnt(lt_cnt_s)
`endif
    );

    bit_comparator #(.OUT_REG(0), .SYNC_STAGES(0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .b1(b1), .b2(b2),
        .c(cc), .d(dc), .e(ec)
`ifdef BC_STATS_EN
        , .gt_cnt(gt_cnt_c), .eq_cnt(eq_cnt_c), .lt_cnt(lt_cnt_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] in;    // {a1, a2, b1, b2}
        logic [2:0] exp;   // {c, d, e}
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cde=%b, expected cde=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_onehot(input string name, input logic [2:0] act);
        n_chk++;
        if (!(act == 3'b100 || act == 3'b010 || act == 3'b001)) begin
            n_fail++;
            $display("FAIL %s: got cde=%b, expected exactly one bit set at %0t", name, act, $time);
        end
    endtask

`ifdef BC_STATS_EN
    task automatic chk_cnt(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Sweep order: a2 toggles each step, a1 every 2, b2 every 4, b1 every 8.
        vecs[0]  = '{4'b0000, 3'b010};  // A=0 B=0
        vecs[1]  = '{4'b0100, 3'b100};  // A=1 B=0
        vecs[2]  = '{4'b1000, 3'b100};  // A=2 B=0
        vecs[3]  = '{4'b1100, 3'b100};  // A=3 B=0
        vecs[4]  = '{4'b0001, 3'b001};  // A=0 B=1
        vecs[5]  = '{4'b0101, 3'b010};  // A=1 B=1
        vecs[6]  = '{4'b1001, 3'b100};  // A=2 B=1
        vecs[7]  = '{4'b1101, 3'b100};  // A=3 B=1
        vecs[8]  = '{4'b0010, 3'b001};  // A=0 B=2
        vecs[9]  = '{4'b0110, 3'b001};  // A=1 B=2
        vecs[10] = '{4'b1010, 3'b010};  // A=2 B=2
        vecs[11] = '{4'b1110, 3'b100};  // A=3 B=2
        vecs[12] = '{4'b0011, 3'b001};  // A=0 B=3
        vecs[13] = '{4'b0111, 3'b001};  // A=1 B=3
        vecs[14] = '{4'b1011, 3'b001};  // A=2 B=3
        vecs[15] = '{4'b1111, 3'b010};  // A=3 B=3

        rst_n = 1'b0;
        {a1, a2, b1, b2} = 4'b1100;
        repeat (3) tick();

        for (int i = 0; i < 3; i++) begin
            chk("rst_reg",  {cr, dr, er}, 3'b010);
            chk("rst_sync", {cs, ds, es}, 3'b010);
            chk("rst_comb", {cc, dc, ec}, 3'b100);
            tick();
        end

        rst_n = 1'b1;
        tick();
        chk("release_edge1", {cr, dr, er}, 3'b010);
        tick();
        chk("release_edge2", {cr, dr, er}, 3'b100);

        for (int i = 0; i < 16; i++) begin
            {a1, a2, b1, b2} = vecs[i].in;
            #1;
            chk($sformatf("sweep_comb[%0d]", i), {cc, dc, ec}, vecs[i].exp);
            tick();
            chk($sformatf("sweep_reg[%0d]", i), {cr, dr, er}, vecs[i].exp);
            chk_onehot($sformatf("onehot_reg[%0d]", i), {cr, dr, er});
            chk_onehot($sformatf("onehot_sync[%0d]", i), {cs, ds, es});
        end

        {a1, a2, b1, b2} = 4'b1100;
        tick();
        chk("pre_async_reset", {cr, dr, er}, 3'b100);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_reg",  {cr, dr, er}, 3'b010);
        chk("async_reset_sync", {cs, ds, es}, 3'b010);
        chk("async_reset_comb", {cc, dc, ec}, 3'b100);
        tick();
        rst_n = 1'b1;

        {a1, a2, b1, b2} = 4'b0001;
        repeat (6) tick();
        chk("latency_pre_sync", {cs, ds, es}, 3'b001);
        chk("latency_pre_comb", {cc, dc, ec}, 3'b001);
        {a1, a2, b1, b2} = 4'b1101;
        #1;
        chk("latency_comb_same_cycle", {cc, dc, ec}, 3'b100);
        tick();
        chk("latency_sync_edge1", {cs, ds, es}, 3'b001);
        tick();
        chk("latency_sync_edge2", {cs, ds, es}, 3'b001);
        tick();
        chk("latency_sync_edge3", {cs, ds, es}, 3'b100);

`ifdef BC_STATS_EN
        rst_n = 1'b0;
        {a1, a2, b1, b2} = 4'b1001;
        tick();
        chk_cnt("stats_rst_gt", gt_cnt, 4'd0);
        chk_cnt("stats_rst_eq", eq_cnt, 4'd0);
        chk_cnt("stats_rst_lt", lt_cnt, 4'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk_cnt("stats_gt_saturate", gt_cnt, 4'd15);
        chk_cnt("stats_eq_zero", eq_cnt, 4'd0);
        chk_cnt("stats_lt_zero", lt_cnt, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt("stats_clear_gt", gt_cnt, 4'd0);
        chk_cnt("stats_clear_eq", eq_cnt, 4'd0);
        chk_cnt("stats_clear_lt", lt_cnt, 4'd0);
        tick();
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
